// File: rtl/dot_product_bfloat16_feeder.sv
// rtl/dot_product_bfloat16_feeder.sv - packs K narrow bf16 operand beats into one wide word for the MLP dot-product stack.
// Optional flush-to-zero of subnormal input lanes when DOT_FEEDER_FTZ_EN is defined.
module dot_product_bfloat16_feeder #(
  parameter int K     = 4,
  parameter int B     = 2,
  parameter int FP    = 16,
  parameter int LEN_W = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_cmd_valid,
  input  logic [LEN_W-1:0]   i_cmd_len,
  output logic               o_cmd_ready,
  input  logic               i_valid,
  input  logic [B*FP-1:0]    i_a,
  input  logic [B*FP-1:0]    i_b,
  output logic               o_ready,
  output logic [K*B*FP-1:0]  o_a,
  output logic [K*B*FP-1:0]  o_b,
  output logic               o_first,
  output logic               o_last,
  output logic               o_word_valid,
  output logic               o_err
);

  localparam int BW = B * FP;
  localparam int WW = K * BW;
  localparam int SW = $clog2(K);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             ready_q, ready_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [SW-1:0]    slot_q, slot_d;
  logic             first_pend_q, first_pend_d;
  logic [WW-1:0]    buf_a_q, buf_a_d;
  logic [WW-1:0]    buf_b_q, buf_b_d;
  logic [WW-1:0]    a_q, a_d;
  logic [WW-1:0]    b_q, b_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic             wv_q, wv_d;
  logic             err_q, err_d;
  logic [WW-1:0]    keep;
  logic             cmd_fire, beat_fire, flush;

  // Lanes whose exponent field is zero become signed zero; pass-through otherwise.
  function automatic logic [BW-1:0] lane_filter(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    r = v;
`ifdef DOT_FEEDER_FTZ_EN
    for (int l = 0; l < B; l++) begin
      if (v[l*FP+FP-2 -: 8] == 8'h00) begin
        r[l*FP +: FP] = {v[l*FP+FP-1], {(FP-1){1'b0}}};
      end
    end
`endif
    return r;
  endfunction

  assign cmd_fire  = cmd_ready_q & i_cmd_valid;
  assign beat_fire = ready_q & i_valid;
  assign flush     = beat_fire & ((slot_q == SW'(K-1)) | (remaining_q == LEN_W'(1)));

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    slot_d       = slot_q;
    first_pend_d = first_pend_q;
    buf_a_d      = buf_a_q;
    buf_b_d      = buf_b_q;
    a_d          = '0;
    b_d          = '0;
    first_d      = 1'b0;
    last_d       = 1'b0;
    wv_d         = 1'b0;
    err_d        = 1'b0;
    keep         = '0;
    for (int j = 0; j < K; j++) begin
      if (SW'(j) <= slot_q) keep[j*BW +: BW] = '1;
    end
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          if (i_cmd_len == '0) begin
            err_d = 1'b1;
          end else begin
            remaining_d  = i_cmd_len;
            slot_d       = '0;
            first_pend_d = 1'b1;
            state_d      = RUN;
          end
        end
      end
      RUN: begin
        if (beat_fire) begin
          for (int j = 0; j < K; j++) begin
            if (SW'(j) == slot_q) begin
              buf_a_d[j*BW +: BW] = lane_filter(i_a);
              buf_b_d[j*BW +: BW] = lane_filter(i_b);
            end
          end
          slot_d      = slot_q + SW'(1);
          remaining_d = remaining_q - LEN_W'(1);
          if (flush) begin
            // Slots past the current one belong to no beat of this vector.
            a_d          = buf_a_d & keep;
            b_d          = buf_b_d & keep;
            wv_d         = 1'b1;
            first_d      = first_pend_q;
            last_d       = (remaining_q == LEN_W'(1));
            first_pend_d = 1'b0;
            buf_a_d      = '0;
            buf_b_d      = '0;
            slot_d       = '0;
            if (remaining_q == LEN_W'(1)) state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    cmd_ready_d = (state_d == IDLE);
    ready_d     = (state_d == RUN);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= IDLE;
      cmd_ready_q  <= 1'b0;
      ready_q      <= 1'b0;
      remaining_q  <= '0;
      slot_q       <= '0;
      first_pend_q <= 1'b0;
      buf_a_q      <= '0;
      buf_b_q      <= '0;
      a_q          <= '0;
      b_q          <= '0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
      wv_q         <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      ready_q      <= ready_d;
      remaining_q  <= remaining_d;
      slot_q       <= slot_d;
      first_pend_q <= first_pend_d;
      buf_a_q      <= buf_a_d;
      buf_b_q      <= buf_b_d;
      a_q          <= a_d;
      b_q          <= b_d;
      first_q      <= first_d;
      last_q       <= last_d;
      wv_q         <= wv_d;
      err_q        <= err_d;
    end
  end

  assign o_cmd_ready  = cmd_ready_q;
  assign o_ready      = ready_q;
  assign o_a          = a_q;
  assign o_b          = b_q;
  assign o_first      = first_q;
  assign o_last       = last_q;
  assign o_word_valid = wv_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_dot_product_bfloat16_feeder.sv
// tb/tb_dot_product_bfloat16_feeder.sv - directed-vector bench for dot_product_bfloat16_feeder.
module tb_dot_product_bfloat16_feeder;

  localparam int K     = 4;
  localparam int B     = 2;
  localparam int FP    = 16;
  localparam int LEN_W = 16;
  localparam int BW    = B * FP;
  localparam int WW    = K * BW;

  logic             i_clk = 1'b0;
  logic             i_reset = 1'b1;
  logic             i_cmd_valid = 1'b0;
  logic [LEN_W-1:0] i_cmd_len = '0;
  logic             o_cmd_ready;
  logic             i_valid = 1'b0;
  logic [BW-1:0]    i_a = '0;
  logic [BW-1:0]    i_b = '0;
  logic             o_ready;
  logic [WW-1:0]    o_a;
  logic [WW-1:0]    o_b;
  logic             o_first;
  logic             o_last;
  logic             o_word_valid;
  logic             o_err;

  int vectors = 0;
  int miscompares = 0;

  dot_product_bfloat16_feeder #(.K(K), .B(B), .FP(FP), .LEN_W(LEN_W)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_cmd_valid(i_cmd_valid), .i_cmd_len(i_cmd_len), .o_cmd_ready(o_cmd_ready),
    .i_valid(i_valid), .i_a(i_a), .i_b(i_b), .o_ready(o_ready),
    .o_a(o_a), .o_b(o_b), .o_first(o_first), .o_last(o_last),
    .o_word_valid(o_word_valid), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [BW-1:0] pat_a(input int j);
    logic [15:0] l0;
    l0 = 16'h1000 + 16'(j * 16);
    return {l0 + 16'h0001, l0};
  endfunction

  function automatic logic [BW-1:0] pat_b(input int j);
    logic [15:0] l0;
    l0 = 16'h2000 + 16'(j * 16);
    return {l0 + 16'h0001, l0};
  endfunction

  task automatic issue_cmd(input logic [LEN_W-1:0] len);
    i_cmd_valid = 1'b1;
    i_cmd_len   = len;
    tick();
    i_cmd_valid = 1'b0;
    i_cmd_len   = '0;
  endtask

  task automatic send_beat(input logic [BW-1:0] a, input logic [BW-1:0] b);
    i_valid = 1'b1;
    i_a     = a;
    i_b     = b;
    tick();
    i_valid = 1'b0;
    i_a     = '0;
    i_b     = '0;
  endtask

  task automatic test_reset;
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    vectors++;
    if ({o_cmd_ready, o_ready, o_first, o_last, o_word_valid, o_err, o_a, o_b} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got ctl=%b a=%h b=%h, need all zero",
               {o_cmd_ready, o_ready, o_first, o_last, o_word_valid, o_err}, o_a, o_b);
    end
    i_reset = 1'b0;
    tick();
    vectors++;
    if ({o_cmd_ready, o_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_release_ready: got cmd_ready,ready=%b need 10", {o_cmd_ready, o_ready});
    end
  endtask

  task automatic test_len8;
    logic [2:0]    exp_f;
    logic [WW-1:0] ea, eb;
    int            words;
    words = 0;
    issue_cmd(16'd8);
    vectors++;
    if ({o_cmd_ready, o_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL len8_run_ready: got cmd_ready,ready=%b need 01", {o_cmd_ready, o_ready});
    end
    for (int j = 0; j < 8; j++) begin
      send_beat(32'h3F803F80, 32'h40004000);
      exp_f = (j == 3) ? 3'b101 : (j == 7) ? 3'b011 : 3'b000;
      ea = exp_f[0] ? {K{32'h3F803F80}} : '0;
      eb = exp_f[0] ? {K{32'h40004000}} : '0;
      if (o_word_valid) words++;
      vectors++;
      if ({o_first, o_last, o_word_valid} !== exp_f || o_a !== ea || o_b !== eb) begin
        miscompares++;
        $display("FAIL len8_beat%0d: got fl v=%b a=%h b=%h need %b a=%h b=%h",
                 j, {o_first, o_last, o_word_valid}, o_a, o_b, exp_f, ea, eb);
      end
    end
    vectors++;
    if (words != 2 || o_cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL len8_words: got words=%0d cmd_ready=%b need 2 and 1", words, o_cmd_ready);
    end
  endtask

  task automatic test_len5;
    int wv_cnt;
    wv_cnt = 0;
    issue_cmd(16'd5);
    for (int j = 0; j < 5; j++) begin
      send_beat(pat_a(j), pat_b(j));
      if (o_word_valid) wv_cnt++;
      if (j == 3) begin
        vectors++;
        if ({o_first, o_last, o_word_valid} !== 3'b101 ||
            o_a !== {pat_a(3), pat_a(2), pat_a(1), pat_a(0)} ||
            o_b !== {pat_b(3), pat_b(2), pat_b(1), pat_b(0)}) begin
          miscompares++;
          $display("FAIL len5_word0: got fl v=%b a=%h b=%h", {o_first, o_last, o_word_valid}, o_a, o_b);
        end
      end
    end
    vectors++;
    if ({o_first, o_last, o_word_valid} !== 3'b011 ||
        o_a !== {96'h0, pat_a(4)} || o_b !== {96'h0, pat_b(4)}) begin
      miscompares++;
      $display("FAIL len5_word1: got fl v=%b a=%h b=%h need 011 a=%h",
               {o_first, o_last, o_word_valid}, o_a, o_b, {96'h0, pat_a(4)});
    end
    for (int t = 0; t < 2; t++) begin
      tick();
      if (o_word_valid) wv_cnt++;
    end
    vectors++;
    if (wv_cnt != 2) begin
      miscompares++;
      $display("FAIL len5_wv_count: got %0d need 2", wv_cnt);
    end
  endtask

  task automatic test_gaps;
    issue_cmd(16'd3);
    for (int j = 0; j < 3; j++) begin
      send_beat(pat_a(10 + j), pat_b(10 + j));
      if (j < 2) begin
        for (int g = 0; g < 2; g++) begin
          vectors++;
          if ({o_first, o_last, o_word_valid} !== 3'b000 || o_a !== '0 || o_b !== '0) begin
            miscompares++;
            $display("FAIL gaps_zero_b%0d_c%0d: got fl v=%b a=%h need 000 and zero",
                     j, g, {o_first, o_last, o_word_valid}, o_a);
          end
          tick();
        end
      end
    end
    vectors++;
    if ({o_first, o_last, o_word_valid} !== 3'b111 ||
        o_a !== {32'h0, pat_a(12), pat_a(11), pat_a(10)} ||
        o_b !== {32'h0, pat_b(12), pat_b(11), pat_b(10)}) begin
      miscompares++;
      $display("FAIL gaps_word: got fl v=%b a=%h b=%h need 111 a=%h",
               {o_first, o_last, o_word_valid}, o_a, o_b, {32'h0, pat_a(12), pat_a(11), pat_a(10)});
    end
  endtask

  task automatic test_zero_len;
    i_valid = 1'b1;
    i_a     = pat_a(20);
    i_b     = pat_b(20);
    issue_cmd(16'd0);
    vectors++;
    if ({o_err, o_cmd_ready, o_ready, o_word_valid} !== 4'b1100) begin
      miscompares++;
      $display("FAIL zero_len_err: got err,cmd_ready,ready,wv=%b need 1100",
               {o_err, o_cmd_ready, o_ready, o_word_valid});
    end
    tick();
    vectors++;
    if ({o_err, o_cmd_ready, o_ready, o_word_valid} !== 4'b0100) begin
      miscompares++;
      $display("FAIL zero_len_pulse: got err,cmd_ready,ready,wv=%b need 0100",
               {o_err, o_cmd_ready, o_ready, o_word_valid});
    end
    i_valid = 1'b0;
    i_a     = '0;
    i_b     = '0;
    issue_cmd(16'd1);
    send_beat(pat_a(5), pat_b(5));
    vectors++;
    if ({o_first, o_last, o_word_valid} !== 3'b111 ||
        o_a !== {96'h0, pat_a(5)} || o_b !== {96'h0, pat_b(5)}) begin
      miscompares++;
      $display("FAIL zero_len_next: got fl v=%b a=%h b=%h", {o_first, o_last, o_word_valid}, o_a, o_b);
    end
  endtask

  task automatic test_reset_mid;
    int lasts;
    lasts = 0;
    issue_cmd(16'd8);
    send_beat(pat_a(30), pat_b(30));
    send_beat(pat_a(31), pat_b(31));
    #2;
    i_reset = 1'b1;
    #1;
    vectors++;
    if ({o_cmd_ready, o_ready, o_first, o_last, o_word_valid, o_err, o_a, o_b} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_async: got ctl=%b a=%h need all zero",
               {o_cmd_ready, o_ready, o_first, o_last, o_word_valid, o_err}, o_a);
    end
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    tick();
    if (o_last) lasts++;
    vectors++;
    if (o_cmd_ready !== 1'b1 || lasts != 0) begin
      miscompares++;
      $display("FAIL reset_mid_idle: got cmd_ready=%b lasts=%0d need 1 and 0", o_cmd_ready, lasts);
    end
    issue_cmd(16'd2);
    send_beat(pat_a(6), pat_b(6));
    send_beat(pat_a(7), pat_b(7));
    vectors++;
    if ({o_first, o_last, o_word_valid} !== 3'b111 ||
        o_a !== {64'h0, pat_a(7), pat_a(6)} || o_b !== {64'h0, pat_b(7), pat_b(6)}) begin
      miscompares++;
      $display("FAIL reset_mid_restart: got fl v=%b a=%h b=%h", {o_first, o_last, o_word_valid}, o_a, o_b);
    end
  endtask

  task automatic test_ftz;
    logic [BW-1:0] ea, eb;
`ifdef DOT_FEEDER_FTZ_EN
    ea = {16'h0000, 16'h8000};
    eb = {16'h3F80, 16'h8000};
`else
    ea = {16'h0040, 16'h8001};
    eb = {16'h3F80, 16'h8001};
`endif
    issue_cmd(16'd1);
    send_beat({16'h0040, 16'h8001}, {16'h3F80, 16'h8001});
    vectors++;
    if ({o_first, o_last, o_word_valid} !== 3'b111 || o_a !== {96'h0, ea} || o_b !== {96'h0, eb}) begin
      miscompares++;
      $display("FAIL ftz_lanes: got fl v=%b a=%h b=%h need 111 a=%h b=%h",
               {o_first, o_last, o_word_valid}, o_a[BW-1:0], o_b[BW-1:0], ea, eb);
    end
  endtask

  initial begin
    test_reset();
    test_len8();
    test_len5();
    test_gaps();
    test_zero_len();
    test_reset_mid();
    test_ftz();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dot_product_bfloat16_feeder.md
Name: dot_product_bfloat16_feeder

Overview:
- Upstream stage of the 4-MLP bfloat16 dot-product stack.
- Accepts a command giving the vector length, then a valid/ready stream of narrow bf16 operand beats (B pairs per beat).
- Packs K beats into one K*B-lane word, zero-pads the tail, and drives the stack's a/b/first/last inputs every cycle.
- Idle and stall cycles emit all-zero words with first=last=0. Zero products leave the running sum unchanged.

Parameters:
- K, 4, beats packed per output word (number of MLPs), >= 2
- B, 2, bf16 pairs per input beat (parallel multiplies per MLP)
- FP, 16, floating-point width (bf16, 8-bit exponent)
- LEN_W, 16, width of the vector-length field

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous active-high reset
- i_cmd_valid  in  1  command valid
- i_cmd_len  in  LEN_W  vector length in input beats; 0 is illegal
- o_cmd_ready  out  1  command accepted when valid&ready
- i_valid  in  1  operand beat valid
- i_a  in  B*FP  operand A lanes, lane 0 in LSBs
- i_b  in  B*FP  operand B lanes
- o_ready  out  1  operand beat accepted when valid&ready
- o_a  out  K*B*FP  packed A word; beat j in bits [j*B*FP +: B*FP]
- o_b  out  K*B*FP  packed B word
- o_first  out  1  first word of a vector
- o_last  out  1  last word of a vector
- o_word_valid  out  1  o_a/o_b carry vector data (debug/monitor only)
- o_err  out  1  one-cycle pulse when a zero-length command is rejected

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, all counters and the pack buffer are cleared.
  - All outputs are 0, including o_cmd_ready and o_ready.
  - o_cmd_ready rises on the first clock edge after reset deasserts.
  - Reset during RUN discards the partial word; no o_last is emitted.
- States: IDLE and RUN.
  - IDLE: o_cmd_ready=1, o_ready=0.
    - Command with len>=1: latch remaining=len, slot=0, first_pend=1, go to RUN.
    - Command with len==0: consume it, pulse o_err for 1 cycle, stay in IDLE.
  - RUN: o_cmd_ready=0, o_ready=1. There is no downstream backpressure.
    - Each accepted beat is written to pack slot `slot`; then slot++ and remaining--.
- Flush condition: a beat is accepted with slot==K-1 or remaining==1.
  - On the next clock, o_a/o_b = packed buffer, with unfilled slots forced to 16'h0000 per lane.
  - o_word_valid=1 and o_first=first_pend.
  - o_last=1 if remaining was 1.
  - first_pend clears and the buffer resets.
- Latency: one cycle from the accepting edge of the flushing beat to the registered output word.
- Every non-flush cycle outputs all-zero a/b with o_first=o_last=o_word_valid=0. Input gaps (i_valid=0) insert zero words.
- A vector with len<=K produces a single word with o_first=o_last=1.
- After o_last the block returns to IDLE. The minimum gap between vector commands is 1 cycle: the command is accepted in the cycle after the last beat.
- Number of words per vector = ceil(len/K). Counters saturate at neither end; remaining never underflows because RUN exits when it reaches 0.
- i_valid in IDLE is ignored (o_ready=0). i_cmd_valid in RUN is held off (o_cmd_ready=0).

Optional Feature:
- Macro DOT_FEEDER_FTZ_EN.
- Defined: each input bf16 lane with exponent bits [14:7]==0 (subnormal or zero) is replaced by {sign,15'b0} before packing. This is flush-to-zero, and it adds no latency.
- Undefined: lanes pass through bit-exact.

Test Plan:
- len=8, 8 back-to-back beats with A lane values 1.0 (16'h3F80), B = 2.0 (16'h4000) -> 2 words; word0 first=1 last=0; word1 first=0 last=1; each lane 16'h3F80/16'h4000; downstream sum = 32.0 (16'h4200).
- len=5, continuous beats -> word0 full with first=1; word1 holds beat 4 in slot 0, slots 1..3 = 0, last=1; o_word_valid high exactly 2 cycles.
- len=3 with i_valid low 2 cycles between beats -> zero words with first/last=0 during the gaps; single output word with first=last=1, slot 3 zero.
- i_cmd_len=0 -> o_err pulses for 1 cycle, state stays IDLE, o_ready stays 0; next command len=1 runs normally.
- Assert i_reset after 2 beats of len=8 -> all outputs 0 immediately (asynchronous); no o_last; the next command starts cleanly with first=1.
- With DOT_FEEDER_FTZ_EN, lane 16'h8001 -> 16'h8000 and lane 16'h0040 -> 16'h0000; without the macro both pass unchanged.
